// File: rtl/contador_ajustable.sv
// contador_ajustable: up/down modular counter with press detect, hold-to-repeat, dynamic limit, carry/borrow and load
module contador_ajustable #(
  parameter int WIDTH = 4,
  parameter int MIN_VAL = 1,
  parameter int MAX_VAL = 12,
  parameter int INIT_VAL = 1,
  parameter bit DYN_MAX = 0,
  parameter int HOLD_CYCLES = 50000000,
  parameter int REPEAT_CYCLES = 10000000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             boton_aumenta,
  input  logic             boton_disminuye,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic [WIDTH-1:0] limite_max,
  output logic [WIDTH-1:0] count,
  output logic             carry,
  output logic             borrow,
  output logic             repitiendo
);
  localparam int TMAX = HOLD_CYCLES > REPEAT_CYCLES ? HOLD_CYCLES : REPEAT_CYCLES;
  localparam int TW = $clog2(TMAX);
  localparam logic [WIDTH-1:0] MINV = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] INITV = WIDTH'(INIT_VAL);
  localparam logic [TW-1:0] HLAST = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] RLAST = TW'(REPEAT_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEAT} state_t;
  state_t state;
  logic [TW-1:0] timer;
  logic prev_up, prev_dn, held, press, step, wrap_up, wrap_dn;
  logic [WIDTH-1:0] lim_sat, max_eff, load_sat;
  // effective limit, load saturation and the step decision for this edge
  always_comb begin
    lim_sat = limite_max < MINV ? MINV : (limite_max > MAXV ? MAXV : limite_max);
    max_eff = DYN_MAX ? lim_sat : MAXV;
    load_sat = load_val < MINV ? MINV : (load_val > max_eff ? max_eff : load_val);
    held = boton_aumenta ^ boton_disminuye;
    press = held && (boton_aumenta ? !prev_up : !prev_dn);
    step = held && ((state == IDLE && press) || (state == HOLD_WAIT && timer == HLAST) ||
                    (state == REPEAT && timer == RLAST));
    wrap_up = count >= max_eff;
    wrap_dn = count <= MINV;
  end
  assign repitiendo = state == REPEAT;
  // button history, repeat FSM and count update with load > clamp > step priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= INITV;
      carry <= 1'b0;
      borrow <= 1'b0;
      state <= IDLE;
      timer <= '0;
      prev_up <= 1'b0;
      prev_dn <= 1'b0;
    end else begin
      prev_up <= boton_aumenta;
      prev_dn <= boton_disminuye;
      carry <= 1'b0;
      borrow <= 1'b0;
      if (load) begin
        count <= load_sat;
        state <= IDLE;
        timer <= '0;
      end else begin
        if (!held) begin
          state <= IDLE;
          timer <= '0;
        end else begin
          case (state)
            IDLE: begin
              timer <= '0;
              if (press) state <= HOLD_WAIT;
            end
            HOLD_WAIT: begin
              timer <= timer == HLAST ? '0 : timer + TW'(1);
              if (timer == HLAST) state <= REPEAT;
            end
            REPEAT: timer <= timer == RLAST ? '0 : timer + TW'(1);
            default: begin
              state <= IDLE;
              timer <= '0;
            end
          endcase
        end
        if (count > max_eff) count <= max_eff;
        else if (step && boton_aumenta) begin
          count <= wrap_up ? MINV : count + WIDTH'(1);
          carry <= wrap_up;
        end else if (step) begin
          count <= wrap_dn ? max_eff : count - WIDTH'(1);
          borrow <= wrap_dn;
        end
      end
    end
  end
endmodule

// File: tb/tb_contador_ajustable.sv
// tb_contador_ajustable: directed self-checking bench for contador_ajustable
module tb_contador_ajustable;
  logic clk = 0, rst_n = 0;
  logic a_up = 0, a_dn = 0, a_load = 0;
  logic [3:0] a_load_val = 0, a_lim = 0, a_count;
  logic a_carry, a_borrow, a_rep;
  logic b_up = 0, b_dn = 0, b_load = 0;
  logic [4:0] b_load_val = 0, b_lim = 31, b_count;
  logic b_carry, b_borrow, b_rep;
  int checks = 0, errors = 0;
  int exp_cnt [10] = '{2, 2, 2, 2, 3, 3, 4, 4, 5, 5};

  always #5 clk = ~clk;

  contador_ajustable #(.WIDTH(4), .MIN_VAL(1), .MAX_VAL(12), .INIT_VAL(1), .DYN_MAX(0),
                       .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .boton_aumenta(a_up), .boton_disminuye(a_dn), .load(a_load),
    .load_val(a_load_val), .limite_max(a_lim), .count(a_count), .carry(a_carry),
    .borrow(a_borrow), .repitiendo(a_rep));

  contador_ajustable #(.WIDTH(5), .MIN_VAL(1), .MAX_VAL(31), .INIT_VAL(1), .DYN_MAX(1),
                       .HOLD_CYCLES(4), .REPEAT_CYCLES(2)) u_b (
    .clk(clk), .rst_n(rst_n), .boton_aumenta(b_up), .boton_disminuye(b_dn), .load(b_load),
    .load_val(b_load_val), .limite_max(b_lim), .count(b_count), .carry(b_carry),
    .borrow(b_borrow), .repitiendo(b_rep));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_a(input logic dir_up);
    if (dir_up) a_up = 1; else a_dn = 1;
    @(negedge clk);
    a_up = 0;
    a_dn = 0;
  endtask

  task automatic load_a(input logic [3:0] v);
    a_load_val = v;
    a_load = 1;
    @(negedge clk);
    a_load = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("reset_count", a_count, 1);
    check("reset_carry", a_carry, 0);
    check("reset_borrow", a_borrow, 0);
    check("reset_rep", a_rep, 0);
    pulse_a(1);
    @(negedge clk);
    pulse_a(1);
    check("pre_async", a_count, 3);
    #3 rst_n = 0;
    #1;
    check("async_count", a_count, 1);
    check("async_carry", a_carry, 0);
    check("async_rep", a_rep, 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    check("post_reset_count", a_count, 1);
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      pulse_a(1);
      check("up_count", a_count, i == 12 ? 1 : i + 1);
      check("up_carry", a_carry, i == 12 ? 1 : 0);
    end
    @(negedge clk);
    check("carry_one_cycle", a_carry, 0);
    pulse_a(0);
    check("dn_wrap_count", a_count, 12);
    check("dn_wrap_borrow", a_borrow, 1);
    @(negedge clk);
    check("borrow_one_cycle", a_borrow, 0);
    pulse_a(0);
    check("dn_count", a_count, 11);
    check("dn_no_borrow", a_borrow, 0);
    @(negedge clk);
    load_a(1);
    check("load_one", a_count, 1);
    a_up = 1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("repeat_count", a_count, exp_cnt[k]);
      check("repeat_flag", a_rep, k >= 4 ? 1 : 0);
    end
    a_up = 0;
    @(negedge clk);
    check("release_count", a_count, 5);
    check("release_rep", a_rep, 0);
    a_up = 1;
    a_dn = 1;
    repeat (6) @(negedge clk);
    check("both_count", a_count, 5);
    check("both_rep", a_rep, 0);
    check("both_carry", a_carry, 0);
    a_dn = 0;
    repeat (6) @(negedge clk);
    check("held_no_press_count", a_count, 5);
    check("held_no_press_rep", a_rep, 0);
    a_up = 0;
    @(negedge clk);
    a_up = 1;
    repeat (5) @(negedge clk);
    check("midrep_count", a_count, 7);
    check("midrep_flag", a_rep, 1);
    #3 rst_n = 0;
    #1;
    check("midrep_reset_count", a_count, 1);
    check("midrep_reset_rep", a_rep, 0);
    check("midrep_reset_carry", a_carry, 0);
    a_up = 0;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    a_up = 1;
    repeat (6) @(negedge clk);
    check("pre_load_rep", a_rep, 1);
    check("pre_load_count", a_count, 3);
    load_a(15);
    check("load_sat_count", a_count, 12);
    check("load_sat_rep", a_rep, 0);
    check("load_sat_carry", a_carry, 0);
    repeat (3) @(negedge clk);
    check("after_load_count", a_count, 12);
    check("after_load_rep", a_rep, 0);
    a_up = 0;
    @(negedge clk);
    load_a(0);
    check("load_zero", a_count, 1);
    b_load_val = 31;
    b_load = 1;
    @(negedge clk);
    b_load = 0;
    check("dyn_load", b_count, 31);
    b_lim = 28;
    @(negedge clk);
    check("dyn_clamp_count", b_count, 28);
    check("dyn_clamp_borrow", b_borrow, 0);
    b_up = 1;
    @(negedge clk);
    b_up = 0;
    check("dyn_wrap_count", b_count, 1);
    check("dyn_wrap_carry", b_carry, 1);
    @(negedge clk);
    b_load_val = 30;
    b_load = 1;
    @(negedge clk);
    b_load = 0;
    check("dyn_load_sat", b_count, 28);
    b_lim = 0;
    @(negedge clk);
    check("dyn_lim_floor", b_count, 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/contador_ajustable.md
Name: contador_ajustable

Overview:
- Parametrised up/down modular counter for user-adjusted date/time fields: month, day, hour, minute, year-low.
- Adds several features over a plain per-clock button counter:
  - rising-edge press detection and hold-to-auto-repeat;
  - runtime-variable upper limit, e.g. days-in-month fed from the month field;
  - carry/borrow pulses for cascading fields;
  - synchronous load.
- Sits between the synchronised button inputs and the clock/calendar display and register logic.

Parameters:
- WIDTH, 4: counter width in bits.
- MIN_VAL, 1: lowest legal count value.
- MAX_VAL, 12: highest legal count value; also the static limit when DYN_MAX=0.
- INIT_VAL, 1: count value after reset.
- DYN_MAX, 0: 1 = upper limit comes from port limite_max.
- HOLD_CYCLES, 50000000: held cycles after a press before auto-repeat starts (>=2).
- REPEAT_CYCLES, 10000000: cycles between auto-repeat steps (>=2).

Ports:
- clk, input, 1: system clock, rising edge.
- rst_n, input, 1: asynchronous reset, active-low.
- boton_aumenta, input, 1: increment button, already synchronised, level.
- boton_disminuye, input, 1: decrement button, already synchronised, level.
- load, input, 1: synchronous load strobe.
- load_val, input, WIDTH: value to load.
- limite_max, input, WIDTH: dynamic upper limit; ignored when DYN_MAX=0.
- count, output, WIDTH: current value.
- carry, output, 1: one-cycle pulse on up-wrap.
- borrow, output, 1: one-cycle pulse on down-wrap.
- repitiendo, output, 1: high while in REPEAT state.

Behaviour:
- Reset (rst_n low, async): count=INIT_VAL, carry=0, borrow=0, state=IDLE, timer=0, previous-button registers=0.
  - A button held when reset releases counts as a press on the first clock edge.
- Effective max (max_eff):
  - DYN_MAX=0: max_eff = MAX_VAL.
  - DYN_MAX=1: max_eff = limite_max, saturated into [MIN_VAL, MAX_VAL].
- Step up: if count >= max_eff, count = MIN_VAL and carry=1 for that cycle; else count+1.
- Step down: if count <= MIN_VAL, count = max_eff and borrow=1 for that cycle; else count-1.
- carry/borrow are registered, high exactly the one cycle after the wrapping edge, otherwise 0.
- Press: button sampled 1 at an edge where its previous sample is 0. The step happens at that same edge, so count changes one cycle after the button rises.
- FSM (shared by both buttons; exactly one button held = "held"):
  - IDLE:
    - aumenta press alone -> step up, go to HOLD_WAIT, timer=0.
    - disminuye press alone -> step down, go to HOLD_WAIT, timer=0.
  - HOLD_WAIT:
    - held and timer==HOLD_CYCLES-1 -> step, go to REPEAT, timer=0.
    - held otherwise -> timer+1.
  - REPEAT:
    - held and timer==REPEAT_CYCLES-1 -> step in the held direction, timer=0.
    - held otherwise -> timer+1.
  - Any state: release, or both buttons high -> IDLE, timer=0, no step.
- Both buttons pressed or high on the same edge: no step, no carry/borrow.
- Priority per edge, highest first:
  1. load: count = load_val saturated into [MIN_VAL, max_eff]; no carry/borrow; state -> IDLE; press edges that cycle discarded.
  2. clamp: if count > max_eff, count = max_eff; no borrow; state/timer unaffected; step suppressed that edge.
  3. step.
- Timer width = clog2 of max(HOLD_CYCLES, REPEAT_CYCLES).
- All arithmetic is within WIDTH bits; MAX_VAL < 2^WIDTH is required, so no natural overflow.
- Reset mid-repeat: immediate return to reset values; carry/borrow are never left high.

Test Plan (HOLD_CYCLES=4, REPEAT_CYCLES=2 unless noted):
1. Reset: assert rst_n=0 asynchronously mid-cycle -> count=1, carry=0, borrow=0, repitiendo=0 immediately; holds after release with buttons low.
2. Up wrap: twelve single-cycle boton_aumenta pulses from count=1 -> count 2..12 then 1.
   - carry high exactly one cycle, after the 12th pulse only.
3. Down wrap: one boton_disminuye pulse at count=1 -> count=12, borrow one cycle.
   - Next pulse -> 11, no borrow.
4. Auto-repeat: hold boton_aumenta for 10 edges from count=1 -> steps at edges 0, 4, 6, 8; final count=5.
   - repitiendo high from edge 4 until release.
   - Both buttons held together -> count frozen, state IDLE.
5. Dynamic limit: DYN_MAX=1, MAX_VAL=31, count=31; limite_max 31 -> 28.
   - count=28 next edge, no borrow.
   - Then an up press -> count=1 with carry.
6. Load: load=1, load_val=15 with limit 12 during REPEAT -> count=12, state IDLE, no carry.
   - load_val=0 -> count=1.
